// File: rtl/bbc_bus_responder_pkg.sv
// Shared definitions for the BBC motherboard bus responder: FSM states, address regions,
// IO window bounds and the bus-to-backing-memory address map.
package bbc_bus_responder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_DRIVE,
        ST_WR_WAIT,
        ST_WR_REQ,
        ST_HOLD
    } state_t;

    typedef enum logic [1:0] {
        RGN_RAM,
        RGN_ROM,
        RGN_MOS,
        RGN_IO
    } region_t;

    localparam logic [15:0] FE30_ADR = 16'hFE30;
    localparam logic [15:0] IO_LO    = 16'hFC00;
    localparam logic [15:0] IO_HI    = 16'hFEFF;
    localparam int unsigned MAP_W    = 20;

    function automatic region_t decode_region(input logic [15:0] adr);
        region_t r;
        if (!adr[15])
            r = RGN_RAM;
        else if (!adr[14])
            r = RGN_ROM;
        else if (adr >= IO_LO && adr <= IO_HI)
            r = RGN_IO;
        else
            r = RGN_MOS;
        return r;
    endfunction

    // Paged ROM space picks its bank from the FE30 shadow current at the phi2 rise.
    function automatic logic [MAP_W-1:0] map_adr(input logic [15:0] adr, input logic [3:0] bank);
        logic [MAP_W-1:0] m;
        m = '0;
        case (decode_region(adr))
            RGN_RAM: m = {5'b00000, adr[14:0]};
            RGN_ROM: m = {2'b01, bank, adr[13:0]};
            RGN_MOS: m = {6'b000001, adr[13:0]};
            default: m = '0;
        endcase
        return m;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/bbc_bus_responder_sync.sv
// Multi-stage synchroniser for phi2 plus a vector of bus signals sharing the same depth,
// with rise/fall pulses derived from the synchronised phi2.
module bbc_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned W           = 1
) (
    input  logic         clk,
    input  logic         sig_i,
    input  logic [W-1:0] vec_i,
    output logic [W-1:0] vec_o,
    output logic         rise_o,
    output logic         fall_o
);

    logic [SYNC_STAGES-1:0] sig_sync_q;
    logic                   sig_prev_q;
    logic [W-1:0]           vec_sync_q [SYNC_STAGES];

    // No reset: the chains keep tracking the pins through reset so a phi2 already high
    // when reset drops cannot masquerade as a fresh rise.
    always_ff @(posedge clk) begin
        sig_sync_q    <= {sig_sync_q[SYNC_STAGES-2:0], sig_i};
        sig_prev_q    <= sig_sync_q[SYNC_STAGES-1];
        vec_sync_q[0] <= vec_i;
        for (int unsigned i = 1; i < SYNC_STAGES; i++)
            vec_sync_q[i] <= vec_sync_q[i-1];
    end

    assign vec_o  = vec_sync_q[SYNC_STAGES-1];
    assign rise_o = sig_sync_q[SYNC_STAGES-1] & ~sig_prev_q;
    assign fall_o = ~sig_sync_q[SYNC_STAGES-1] & sig_prev_q;

endmodule

// File: rtl/bbc_bus_responder.sv
// BBC motherboard bus responder: decodes phi2 cycles onto a req/ack memory port and shadows FE30.
// Optional macro SYNC_TRACK_EN adds bbc_sync input and mos_vdu_sync output.
module bbc_bus_responder
    import bbc_bus_responder_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned PHI2_HOLD_CYC = 2,
    parameter int unsigned MEM_ADR_SZ    = 20
) (
    input  logic                  hsclk,
    input  logic                  rst,
    input  logic                  bbc_phi2,
    input  logic                  bbc_rnw,
    input  logic [15:0]           bbc_adr,
    input  logic [7:0]            bbc_data_in,
    output logic [7:0]            bbc_data_out,
    output logic                  bbc_data_oe,
    output logic                  mem_req,
    output logic                  mem_rnw,
    output logic [MEM_ADR_SZ-1:0] mem_adr,
    output logic [7:0]            mem_wdata,
    input  logic                  mem_ack,
    input  logic [7:0]            mem_rdata,
    output logic [3:0]            romsel_q,
    output logic                  io_cycle,
    output logic [7:0]            late_cnt
`ifdef SYNC_TRACK_EN
    ,
    input  logic                  bbc_sync,
    output logic                  mos_vdu_sync
`endif
);

    localparam logic [2:0] HOLD_INIT = (PHI2_HOLD_CYC == 0) ? 3'd0 : 3'(PHI2_HOLD_CYC - 1);

`ifdef SYNC_TRACK_EN
    localparam int unsigned VEC_W = 26;
    logic [VEC_W-1:0] vec_in;
    logic [VEC_W-1:0] vec_s;
    logic             s_sync;
    assign vec_in = {bbc_sync, bbc_data_in, bbc_adr, bbc_rnw};
    assign s_sync = vec_s[25];
`else
    localparam int unsigned VEC_W = 25;
    logic [VEC_W-1:0] vec_in;
    logic [VEC_W-1:0] vec_s;
    assign vec_in = {bbc_data_in, bbc_adr, bbc_rnw};
`endif

    logic        rise, fall;
    logic        s_rnw;
    logic [15:0] s_adr;
    logic [7:0]  s_data;
    region_t     rgn;
    logic        is_fe30;

    bbc_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .W           (VEC_W)
    ) u_sync (
        .clk    (hsclk),
        .sig_i  (bbc_phi2),
        .vec_i  (vec_in),
        .vec_o  (vec_s),
        .rise_o (rise),
        .fall_o (fall)
    );

    assign s_rnw   = vec_s[0];
    assign s_adr   = vec_s[16:1];
    assign s_data  = vec_s[24:17];
    assign rgn     = decode_region(s_adr);
    assign is_fe30 = (s_adr == FE30_ADR);

    state_t                state_q, state_d;
    logic                  mreq_q, mreq_d;
    logic                  mrnw_q, mrnw_d;
    logic [MEM_ADR_SZ-1:0] madr_q, madr_d;
    logic [7:0]            mwdata_q, mwdata_d;
    logic [7:0]            dout_q, dout_d;
    logic                  oe_q, oe_d;
    logic [3:0]            bank_q, bank_d;
    logic [7:0]            late_q, late_d;
    logic                  io_q, io_d;
    logic [2:0]            hold_q, hold_d;
    logic                  late_rd_q, late_rd_d;
    logic                  wr_io_q, wr_io_d;
    logic                  wr_fe30_q, wr_fe30_d;
    logic [7:0]            data_prev_q;
`ifdef SYNC_TRACK_EN
    logic                  vdu_q, vdu_d;
`endif

    always_ff @(posedge hsclk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mreq_q      <= 1'b0;
            mrnw_q      <= 1'b0;
            madr_q      <= '0;
            mwdata_q    <= '0;
            dout_q      <= '0;
            oe_q        <= 1'b0;
            bank_q      <= '0;
            late_q      <= '0;
            io_q        <= 1'b0;
            hold_q      <= '0;
            late_rd_q   <= 1'b0;
            wr_io_q     <= 1'b0;
            wr_fe30_q   <= 1'b0;
            data_prev_q <= '0;
`ifdef SYNC_TRACK_EN
            vdu_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mreq_q      <= mreq_d;
            mrnw_q      <= mrnw_d;
            madr_q      <= madr_d;
            mwdata_q    <= mwdata_d;
            dout_q      <= dout_d;
            oe_q        <= oe_d;
            bank_q      <= bank_d;
            late_q      <= late_d;
            io_q        <= io_d;
            hold_q      <= hold_d;
            late_rd_q   <= late_rd_d;
            wr_io_q     <= wr_io_d;
            wr_fe30_q   <= wr_fe30_d;
            data_prev_q <= s_data;
`ifdef SYNC_TRACK_EN
            vdu_q       <= vdu_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        mreq_d    = mreq_q;
        mrnw_d    = mrnw_q;
        madr_d    = madr_q;
        mwdata_d  = mwdata_q;
        dout_d    = dout_q;
        oe_d      = oe_q;
        bank_d    = bank_q;
        late_d    = late_q;
        io_d      = 1'b0;
        hold_d    = hold_q;
        late_rd_d = late_rd_q;
        wr_io_d   = wr_io_q;
        wr_fe30_d = wr_fe30_q;
`ifdef SYNC_TRACK_EN
        vdu_d     = vdu_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    io_d   = (rgn == RGN_IO);
                    madr_d = MEM_ADR_SZ'(map_adr(s_adr, bank_q));
                    if (s_rnw) begin
`ifdef SYNC_TRACK_EN
                        if (s_sync)
                            vdu_d = (s_adr[15:13] == 3'b110);
`endif
                        if (rgn == RGN_IO) begin
                            state_d = ST_RD_DRIVE;
                            oe_d    = 1'b1;
                            dout_d  = is_fe30 ? {4'h0, bank_q} : 8'hFF;
                        end else begin
                            state_d   = ST_RD_REQ;
                            mreq_d    = 1'b1;
                            mrnw_d    = 1'b1;
                            late_rd_d = 1'b0;
                        end
                    end else begin
                        state_d   = ST_WR_WAIT;
                        wr_io_d   = (rgn == RGN_IO);
                        wr_fe30_d = is_fe30;
                    end
                end
            end

            ST_RD_REQ: begin
                if (mem_ack) begin
                    mreq_d = 1'b0;
                    if (late_rd_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        dout_d  = mem_rdata;
                        oe_d    = 1'b1;
                        state_d = ST_RD_DRIVE;
                        // Ack landing on the fall cycle goes straight into the hold tail.
                        if (fall) begin
                            if (PHI2_HOLD_CYC == 0) begin
                                state_d = ST_IDLE;
                                oe_d    = 1'b0;
                                dout_d  = '0;
                            end else begin
                                state_d = ST_HOLD;
                                hold_d  = HOLD_INIT;
                            end
                        end
                    end
                end else if (fall && !late_rd_q) begin
                    late_rd_d = 1'b1;
                    late_d    = sat_inc8(late_q);
                end
                if (rise && late_rd_q)
                    late_d = sat_inc8(late_q);
            end

            ST_RD_DRIVE: begin
                if (fall) begin
                    if (PHI2_HOLD_CYC == 0) begin
                        state_d = ST_IDLE;
                        oe_d    = 1'b0;
                        dout_d  = '0;
                    end else begin
                        state_d = ST_HOLD;
                        hold_d  = HOLD_INIT;
                    end
                end
            end

            ST_HOLD: begin
                if (hold_q == 3'd0) begin
                    state_d = ST_IDLE;
                    oe_d    = 1'b0;
                    dout_d  = '0;
                end else begin
                    hold_d = hold_q - 3'd1;
                end
            end

            ST_WR_WAIT: begin
                if (fall) begin
                    if (wr_fe30_q)
                        bank_d = data_prev_q[3:0];
                    if (wr_io_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d  = ST_WR_REQ;
                        mreq_d   = 1'b1;
                        mrnw_d   = 1'b0;
                        mwdata_d = data_prev_q;
                    end
                end
            end

            ST_WR_REQ: begin
                if (mem_ack) begin
                    mreq_d  = 1'b0;
                    state_d = ST_IDLE;
                end
                if (rise)
                    late_d = sat_inc8(late_q);
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign bbc_data_out = dout_q;
    assign bbc_data_oe  = oe_q;
    assign mem_req      = mreq_q;
    assign mem_rnw      = mrnw_q;
    assign mem_adr      = madr_q;
    assign mem_wdata    = mwdata_q;
    assign romsel_q     = bank_q;
    assign io_cycle     = io_q;
    assign late_cnt     = late_q;
`ifdef SYNC_TRACK_EN
    assign mos_vdu_sync = vdu_q;
`endif

endmodule

// File: tb/tb_bbc_bus_responder.sv
// Directed self-checking bench for bbc_bus_responder: bus cycles driven on bbc_phi2, a
// negedge-driven memory responder, and immediate assertions on hand-computed expectations.
module tb_bbc_bus_responder;

    logic        hsclk = 1'b0;
    logic        rst;
    logic        bbc_phi2;
    logic        bbc_rnw;
    logic [15:0] bbc_adr;
    logic [7:0]  bbc_data_in;
    logic [7:0]  bbc_data_out;
    logic        bbc_data_oe;
    logic        mem_req;
    logic        mem_rnw;
    logic [19:0] mem_adr;
    logic [7:0]  mem_wdata;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = 8'h00;
    logic [3:0]  romsel_q;
    logic        io_cycle;
    logic [7:0]  late_cnt;
`ifdef SYNC_TRACK_EN
    logic        bbc_sync;
    logic        mos_vdu_sync;
`endif

    bbc_bus_responder #(
        .SYNC_STAGES   (2),
        .PHI2_HOLD_CYC (2),
        .MEM_ADR_SZ    (20)
    ) dut (
        .hsclk        (hsclk),
        .rst          (rst),
        .bbc_phi2     (bbc_phi2),
        .bbc_rnw      (bbc_rnw),
        .bbc_adr      (bbc_adr),
        .bbc_data_in  (bbc_data_in),
        .bbc_data_out (bbc_data_out),
        .bbc_data_oe  (bbc_data_oe),
        .mem_req      (mem_req),
        .mem_rnw      (mem_rnw),
        .mem_adr      (mem_adr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .romsel_q     (romsel_q),
        .io_cycle     (io_cycle),
        .late_cnt     (late_cnt)
`ifdef SYNC_TRACK_EN
        ,
        .bbc_sync     (bbc_sync),
        .mos_vdu_sync (mos_vdu_sync)
`endif
    );

    always #5 hsclk = ~hsclk;

    int total = 0;
    int bad   = 0;

    // Memory responder / bus monitor settings, written only by the stimulus block.
    int         ack_dly = 2;
    logic [7:0] rd_val  = 8'h00;

    // Responder/monitor state, written only by the negedge block below.
    int          wcnt       = 0;
    int          req_cnt    = 0;
    int          unstable   = 0;
    int          io_cnt     = 0;
    int          oe_cnt     = 0;
    int          oe_pre_cnt = 0;
    logic [19:0] cap_adr    = '0;
    logic        cap_rnw    = 1'b0;
    logic [7:0]  cap_wd     = '0;
    logic [7:0]  oe_val     = '0;

    always @(negedge hsclk) begin
        if (io_cycle)
            io_cnt = io_cnt + 1;
        if (bbc_data_oe) begin
            oe_cnt = oe_cnt + 1;
            oe_val = bbc_data_out;
            if (bbc_phi2)
                oe_pre_cnt = oe_pre_cnt + 1;
        end
        if (mem_ack) begin
            mem_ack = 1'b0;
        end else if (!mem_req) begin
            wcnt = 0;
        end else begin
            if (wcnt == 0) begin
                req_cnt = req_cnt + 1;
                cap_adr = mem_adr;
                cap_rnw = mem_rnw;
                cap_wd  = mem_wdata;
            end else if (mem_adr !== cap_adr || mem_rnw !== cap_rnw || mem_wdata !== cap_wd) begin
                unstable = unstable + 1;
            end
            if (wcnt >= ack_dly) begin
                mem_ack   = 1'b1;
                mem_rdata = rd_val;
                wcnt      = 0;
            end else begin
                wcnt = wcnt + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_cycle(input logic [15:0] a, input logic rnw, input logic [7:0] d);
        @(negedge hsclk);
        bbc_adr     = a;
        bbc_rnw     = rnw;
        bbc_data_in = d;
        repeat (4) @(negedge hsclk);
        bbc_phi2 = 1'b1;
        repeat (16) @(negedge hsclk);
        bbc_phi2 = 1'b0;
        repeat (16) @(negedge hsclk);
    endtask

    initial begin
        int r0, i0, o0, p0, u0;

        rst         = 1'b1;
        bbc_phi2    = 1'b0;
        bbc_rnw     = 1'b1;
        bbc_adr     = '0;
        bbc_data_in = '0;
`ifdef SYNC_TRACK_EN
        bbc_sync    = 1'b0;
`endif
        repeat (5) @(negedge hsclk);
        check("rst_oe",      32'(bbc_data_oe),  32'h0);
        check("rst_dout",    32'(bbc_data_out), 32'h0);
        check("rst_req",     32'(mem_req),      32'h0);
        check("rst_romsel",  32'(romsel_q),     32'h0);
        check("rst_late",    32'(late_cnt),     32'h0);
        check("rst_io",      32'(io_cycle),     32'h0);
`ifdef SYNC_TRACK_EN
        check("rst_vdu",     32'(mos_vdu_sync), 32'h0);
`endif
        rst = 1'b0;
        repeat (4) @(negedge hsclk);
        u0 = unstable;

        // 1: RAM read 0x1234, ack 2 cycles after request.
        ack_dly = 2; rd_val = 8'hA5;
        r0 = req_cnt; p0 = oe_pre_cnt;
        bus_cycle(16'h1234, 1'b1, 8'h00);
        check("t1_req_count", 32'(req_cnt - r0),          32'd1);
        check("t1_adr",       32'(cap_adr),               32'h01234);
        check("t1_rnw",       32'(cap_rnw),               32'h1);
        check("t1_oe_in_win", 32'(oe_pre_cnt - p0 > 0),   32'h1);
        check("t1_dout",      32'(oe_val),                32'hA5);
        check("t1_oe_off",    32'(bbc_data_oe),           32'h0);

        // 2: FE30 <- 0x0C (IO, no request), then paged ROM read 0x8001 -> {01,C,0001}.
        r0 = req_cnt; i0 = io_cnt;
        bus_cycle(16'hFE30, 1'b0, 8'h0C);
        check("t2_fe30_noreq", 32'(req_cnt - r0), 32'd0);
        check("t2_fe30_io",    32'(io_cnt - i0),  32'd1);
        check("t2_romsel",     32'(romsel_q),     32'hC);
        rd_val = 8'h5A; r0 = req_cnt;
        bus_cycle(16'h8001, 1'b1, 8'h00);
        check("t2_rom_req",  32'(req_cnt - r0), 32'd1);
        check("t2_rom_adr",  32'(cap_adr),      32'h70001);
        check("t2_rom_dout", 32'(oe_val),       32'h5A);

        // 3: RAM write at top of RAM, then IO reads and region boundaries.
        r0 = req_cnt;
        bus_cycle(16'h7FFF, 1'b0, 8'h3C);
        check("t3_wr_req", 32'(req_cnt - r0), 32'd1);
        check("t3_wr_rnw", 32'(cap_rnw),      32'h0);
        check("t3_wr_adr", 32'(cap_adr),      32'h07FFF);
        check("t3_wr_dat", 32'(cap_wd),       32'h3C);
        r0 = req_cnt; i0 = io_cnt; o0 = oe_cnt;
        bus_cycle(16'hFE40, 1'b1, 8'h00);
        check("t3_io_noreq",  32'(req_cnt - r0), 32'd0);
        check("t3_io_pulse",  32'(io_cnt - i0),  32'd1);
        check("t3_io_dout",   32'(oe_val),       32'hFF);
        check("t3_io_oe_cyc", 32'(oe_cnt - o0),  32'd18);
        bus_cycle(16'hFE30, 1'b1, 8'h00);
        check("t3_fe30_rd",   32'(oe_val),       32'h0C);
        i0 = io_cnt; r0 = req_cnt;
        bus_cycle(16'hFC00, 1'b1, 8'h00);
        check("t3_fc00_io",   32'(io_cnt - i0),  32'd1);
        check("t3_fc00_req",  32'(req_cnt - r0), 32'd0);
        rd_val = 8'h11;
        bus_cycle(16'hFBFF, 1'b1, 8'h00);
        check("t3_fbff_adr",  32'(cap_adr),      32'h07BFF);
        check("t3_fbff_dout", 32'(oe_val),       32'h11);
        bus_cycle(16'hFF00, 1'b1, 8'h00);
        check("t3_ff00_adr",  32'(cap_adr),      32'h07F00);
        check("t3_ff00_io",   32'(io_cnt - i0),  32'd1);

        // 4: ack arrives after the phi2 fall -> no drive, late_cnt counts and saturates.
        ack_dly = 20; o0 = oe_cnt;
        bus_cycle(16'h0100, 1'b1, 8'h00);
        check("t4_late_one", 32'(late_cnt),     32'h01);
        check("t4_no_oe",    32'(oe_cnt - o0),  32'd0);
        check("t4_req_off",  32'(mem_req),      32'h0);
        for (int k = 0; k < 254; k++)
            bus_cycle(16'h0100, 1'b1, 8'h00);
        check("t4_late_255", 32'(late_cnt),     32'hFF);
        for (int k = 0; k < 45; k++)
            bus_cycle(16'h0100, 1'b1, 8'h00);
        check("t4_late_sat", 32'(late_cnt),     32'hFF);

        // 5: reset while a read request is outstanding.
        ack_dly = 100;
        @(negedge hsclk);
        bbc_adr = 16'h1234; bbc_rnw = 1'b1;
        repeat (4) @(negedge hsclk);
        bbc_phi2 = 1'b1;
        repeat (8) @(negedge hsclk);
        check("t5_req_pre", 32'(mem_req), 32'h1);
        rst = 1'b1;
        @(negedge hsclk);
        rst = 1'b0;
        check("t5_req",    32'(mem_req),     32'h0);
        check("t5_rnw",    32'(mem_rnw),     32'h0);
        check("t5_adr",    32'(mem_adr),     32'h0);
        check("t5_oe",     32'(bbc_data_oe), 32'h0);
        check("t5_romsel", 32'(romsel_q),    32'h0);
        check("t5_late",   32'(late_cnt),    32'h0);
        repeat (8) @(negedge hsclk);
        bbc_phi2 = 1'b0;
        repeat (16) @(negedge hsclk);
        check("t5_no_redecode", 32'(mem_req), 32'h0);
        ack_dly = 2; rd_val = 8'h77; r0 = req_cnt;
        bus_cycle(16'h8001, 1'b1, 8'h00);
        check("t5_next_req",  32'(req_cnt - r0), 32'd1);
        check("t5_next_adr",  32'(cap_adr),      32'h40001);
        check("t5_next_dout", 32'(oe_val),       32'h77);
        check("t5_late_kept", 32'(late_cnt),     32'h0);

`ifdef SYNC_TRACK_EN
        // 6: sync-flagged fetches from the VDU driver window and outside it.
        bbc_sync = 1'b1;
        bus_cycle(16'hC100, 1'b1, 8'h00);
        check("t6_vdu_c100", 32'(mos_vdu_sync), 32'h1);
        bbc_sync = 1'b0;
        bus_cycle(16'hE000, 1'b1, 8'h00);
        check("t6_vdu_hold", 32'(mos_vdu_sync), 32'h1);
        bbc_sync = 1'b1;
        bus_cycle(16'hE000, 1'b1, 8'h00);
        check("t6_vdu_e000", 32'(mos_vdu_sync), 32'h0);
        bbc_sync = 1'b0;
`endif

        check("req_stable", 32'(unstable - u0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
